rx_fifo: RTL and testbench
==========================

RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 Parameter: DEPTH, 8, number of byte entries; power of two, 2..64.
REQ-002 Parameter: AW, 3, pointer width, equal to log2(DEPTH).
REQ-003 Port: baud_clk  input  1  sole clock; 16x oversample clock shared with the UART receiver; all logic on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: RX_DATA  input  8  received byte from the UART receiver; stable when RX_STATUS rises.
REQ-006 Port: RX_STATUS  input  1  receiver frame-done level; stays high until the next frame starts.
REQ-007 Port: rd_en  input  1  consumer read request, one byte per cycle.
REQ-008 Port: ovf_clr  input  1  synchronous clear of the overflow flag.
REQ-009 Port: rd_data  output  8  byte read from the FIFO head.
REQ-010 Port: rd_valid  output  1  rd_data qualifier.
REQ-011 Port: empty  output  1  high when count is 0.
REQ-012 Port: full  output  1  high when count equals DEPTH.
REQ-013 Port: count  output  AW+1  number of stored bytes, 0..DEPTH.
REQ-014 Port: overflow  output  1  sticky flag: a byte was dropped.

Function
REQ-015 The block SHALL register RX_STATUS once and generate a one-cycle write strobe wr when RX_STATUS is 1 and its registered copy is 0.
REQ-016 A held-high RX_STATUS SHALL produce exactly one wr per rising edge.
REQ-017 On wr with full=0, RX_DATA SHALL be written at wptr, wptr SHALL increment modulo DEPTH, and count SHALL increment.
REQ-018 On rd_en with empty=0, the head entry SHALL be consumed, rptr SHALL increment modulo DEPTH, and count SHALL decrement.
REQ-019 rd_en while empty=1 SHALL be ignored, with no pointer, count or flag change.
REQ-020 wr and a valid read in the same cycle SHALL both take effect and leave count unchanged, including when full=1.
REQ-021 On an empty FIFO, wr and rd_en in the same cycle SHALL perform the write only; the read is ignored.
REQ-022 wr while full=1 without a simultaneous valid read SHALL drop the byte, leave the storage unchanged, and set overflow the next cycle.
REQ-023 overflow SHALL stay set until ovf_clr=1 or reset; a simultaneous ovf_clr and new overflow event SHALL leave overflow=1.
REQ-024 empty, full and count SHALL be registered and SHALL reflect the updated state one cycle after the edge that changed it.
REQ-025 Pointer wrap from DEPTH-1 to 0 SHALL preserve FIFO order.

Reset
REQ-026 When reset=0, wptr, rptr, count, overflow, rd_valid and the RX_STATUS history register SHALL clear to 0 immediately, and rd_data SHALL clear to 8'h00.
REQ-027 After reset, empty SHALL be 1 and full SHALL be 0.
REQ-028 Storage contents SHALL NOT be reset.
REQ-029 A reset mid-frame or while RX_STATUS=1 SHALL discard all data and produce no wr until RX_STATUS is next seen low then high.

Configuration
REQ-030 With macro RX_FIFO_FWFT_EN defined, the FIFO SHALL be first-word-fall-through: rd_data SHALL equal the head entry whenever empty=0, rd_valid SHALL equal !empty, and rd_en SHALL acknowledge the presented byte.
REQ-031 Without RX_FIFO_FWFT_EN, rd_data SHALL be registered: a valid read at cycle N SHALL drive the head byte on rd_data with rd_valid=1 at cycle N+1.
REQ-032 Without RX_FIFO_FWFT_EN, rd_valid SHALL be 0 in every other cycle, and rd_data SHALL hold its last value.

Verification
REQ-033 Pulse RX_STATUS three times with RX_DATA 8'h41, 8'h42, 8'h43, then read three times -> rd_data 41, 42, 43 in order; count goes 3 to 0; empty=1.
REQ-034 Hold RX_STATUS high for 100 cycles with RX_DATA 8'h55 -> count=1.
REQ-035 Write 9 bytes 8'h00..8'h08 with DEPTH=8 and no reads -> full=1, overflow=1, and the reads return 00..07.
REQ-036 At full, apply wr with 8'hAA and rd_en in the same cycle -> count stays 8 and overflow stays 0; AA is read eighth.
REQ-037 Assert reset with count=5 and overflow=1 -> count=0, empty=1 and overflow=0 immediately; rd_en then yields rd_valid=0.
REQ-038 Run 20 write/read pairs through DEPTH=8 in both macro builds -> data order preserved across pointer wrap; read latency is 0 cycles with RX_FIFO_FWFT_EN and 1 cycle without.

Source files
------------

// File: rtl/rx_fifo.sv
// rx_fifo: byte FIFO loaded on each rising edge of a UART receiver's frame-done level.
// Optional macro RX_FIFO_FWFT_EN selects first-word-fall-through reads; default is registered reads.
module rx_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          baud_clk,
    input  logic          reset,
    input  logic [7:0]    RX_DATA,
    input  logic          RX_STATUS,
    input  logic          rd_en,
    input  logic          ovf_clr,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          overflow_q, overflow_d;
    logic          status_q, status_d;
    logic          armed_q, armed_d;
    logic          wr_s, rd_ok_s, wr_ok_s, ovf_ev_s;

    // Write strobe, read qualification, pointer/count/flag next state.
    always_comb begin
        status_d = RX_STATUS;
        // After reset the receiver level must be seen low before a rising edge can write.
        armed_d  = armed_q | ~RX_STATUS;
        wr_s     = RX_STATUS & ~status_q & armed_q;
        rd_ok_s  = rd_en & ~empty_q;
        wr_ok_s  = wr_s & (~full_q | rd_ok_s);
        ovf_ev_s = wr_s & full_q & ~rd_ok_s;

        if (wr_ok_s) begin
            wptr_d = wptr_q + AW'(1'b1);
        end else begin
            wptr_d = wptr_q;
        end

        if (rd_ok_s) begin
            rptr_d = rptr_q + AW'(1'b1);
        end else begin
            rptr_d = rptr_q;
        end

        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_d = count_q + (AW+1)'(1'b1);
            2'b01:   count_d = count_q - (AW+1)'(1'b1);
            default: count_d = count_q;
        endcase

        empty_d = (count_d == (AW+1)'(1'b0));
        full_d  = (count_d == DEPTH_C);

        // A new drop wins over a simultaneous clear.
        if (ovf_ev_s) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge baud_clk) begin
        if (wr_ok_s) begin
            mem_q[wptr_q] <= RX_DATA;
        end
    end

    // Control state registers.
    always_ff @(posedge baud_clk or negedge reset) begin
        if (!reset) begin
            wptr_q     <= AW'(1'b0);
            rptr_q     <= AW'(1'b0);
            count_q    <= (AW+1)'(1'b0);
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            status_q   <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            status_q   <= status_d;
            armed_q    <= armed_d;
        end
    end

    assign empty    = empty_q;
    assign full     = full_q;
    assign count    = count_q;
    assign overflow = overflow_q;

`ifdef RX_FIFO_FWFT_EN
    // Head entry is presented directly; zero while empty so reset leaves rd_data at 0.
    assign rd_data  = empty_q ? 8'h00 : mem_q[rptr_q];
    assign rd_valid = ~empty_q;
`else
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;

    // Registered read port: the head byte appears the cycle after an accepted read.
    always_comb begin
        rd_valid_d = rd_ok_s;
        if (rd_ok_s) begin
            rd_data_d = mem_q[rptr_q];
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Read output registers.
    always_ff @(posedge baud_clk or negedge reset) begin
        if (!reset) begin
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// Self-checking bench for rx_fifo: directed scenarios plus random traffic against a queue model.
module tb_rx_fifo;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          baud_clk = 1'b0;
    logic          reset;
    logic [7:0]    RX_DATA;
    logic          RX_STATUS;
    logic          rd_en;
    logic          ovf_clr;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: byte queue plus the externally visible flags.
    logic [7:0] m_q[$];
    bit         m_ovf;
    bit         m_prev;
    bit         m_armed;
    bit         m_valid;
    logic [7:0] m_data;

    always #5 baud_clk = ~baud_clk;

    rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .baud_clk  (baud_clk),
        .reset     (reset),
        .RX_DATA   (RX_DATA),
        .RX_STATUS (RX_STATUS),
        .rd_en     (rd_en),
        .ovf_clr   (ovf_clr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf   = 1'b0;
        m_prev  = 1'b0;
        m_armed = 1'b0;
        m_valid = 1'b0;
        m_data  = 8'h00;
    endtask

    task automatic check_state(input string tag);
        logic [7:0] head;
        head = 8'h00;
        if (m_q.size() != 0) head = m_q[0];
        chk({tag, "_count"},    32'(count),    32'(m_q.size()));
        chk({tag, "_empty"},    32'(empty),    32'(m_q.size() == 0));
        chk({tag, "_full"},     32'(full),     32'(m_q.size() == DEPTH));
        chk({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
`ifdef RX_FIFO_FWFT_EN
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'(m_q.size() != 0));
        chk({tag, "_rd_data"},  32'(rd_data),  32'(head));
`else
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'(m_valid));
        chk({tag, "_rd_data"},  32'(rd_data),  32'(m_data));
`endif
    endtask

    // Apply current inputs across one rising edge, update the model, then compare.
    task automatic step(input string tag);
        bit wr, rdv, drop;
        wr   = RX_STATUS && !m_prev && m_armed;
        rdv  = rd_en && (m_q.size() != 0);
        drop = wr && (m_q.size() == DEPTH) && !rdv;
        m_valid = 1'b0;
        if (rdv) begin
            m_data  = m_q.pop_front();
            m_valid = 1'b1;
        end
        if (wr && !drop) m_q.push_back(RX_DATA);
        if (drop) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        m_armed = m_armed || !RX_STATUS;
        m_prev  = RX_STATUS;
        @(posedge baud_clk);
        #1;
        check_state(tag);
    endtask

    task automatic pulse(input logic [7:0] d, input string tag);
        RX_DATA   = d;
        RX_STATUS = 1'b1;
        step(tag);
        RX_STATUS = 1'b0;
        step(tag);
    endtask

    task automatic read_n(input int n, input string tag);
        rd_en = 1'b1;
        repeat (n) step(tag);
        rd_en = 1'b0;
        step(tag);
    endtask

    initial begin
        reset     = 1'b0;
        RX_DATA   = 8'h00;
        RX_STATUS = 1'b0;
        rd_en     = 1'b0;
        ovf_clr   = 1'b0;
        model_reset();
        repeat (2) @(posedge baud_clk);
        #1;
        check_state("reset");
        reset = 1'b1;
        step("idle");

        // Three frames then three reads, in order.
        pulse(8'h41, "p41");
        pulse(8'h42, "p42");
        pulse(8'h43, "p43");
        chk("req033_count3", 32'(count), 32'd3);
        read_n(3, "rd3");
        chk("req033_empty", 32'(empty), 32'd1);

        // Level held high produces a single write.
        RX_DATA   = 8'h55;
        RX_STATUS = 1'b1;
        repeat (100) step("hold");
        RX_STATUS = 1'b0;
        step("hold_end");
        chk("req034_count1", 32'(count), 32'd1);
        read_n(1, "hold_rd");

        // Nine writes into eight entries: last byte dropped.
        for (int i = 0; i < 9; i++) pulse(8'(i), "w9");
        chk("req035_full", 32'(full), 32'd1);
        chk("req035_overflow", 32'(overflow), 32'd1);
        read_n(8, "rd8");
        ovf_clr = 1'b1;
        step("ovf_clr");
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Write and read together at full.
        for (int i = 0; i < DEPTH; i++) pulse(8'($urandom_range(0, 255)), "fill");
        RX_DATA   = 8'hAA;
        RX_STATUS = 1'b1;
        rd_en     = 1'b1;
        step("full_wr_rd");
        RX_STATUS = 1'b0;
        rd_en     = 1'b0;
        step("full_wr_rd2");
        chk("req036_count8", 32'(count), 32'd8);
        chk("req036_no_ovf", 32'(overflow), 32'd0);
        rd_en = 1'b1;
        repeat (7) step("rd_to_aa");
`ifdef RX_FIFO_FWFT_EN
        chk("req036_aa_eighth", 32'(rd_data), 32'hAA);
        step("rd_aa");
`else
        step("rd_aa");
        chk("req036_aa_eighth", 32'(rd_data), 32'hAA);
`endif
        rd_en = 1'b0;
        step("rd_aa_done");

        // Clear and new drop in the same cycle keeps overflow set.
        for (int i = 0; i < DEPTH; i++) pulse(8'(8'h10 + i), "fill2");
        RX_DATA   = 8'h77;
        RX_STATUS = 1'b1;
        ovf_clr   = 1'b1;
        step("clr_vs_drop");
        ovf_clr   = 1'b0;
        RX_STATUS = 1'b0;
        step("clr_vs_drop2");
        chk("req023_ovf_wins", 32'(overflow), 32'd1);
        read_n(3, "rd3b");
        chk("pre_reset_count5", 32'(count), 32'd5);

        // Reset mid-frame with data and overflow present.
        RX_STATUS = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        check_state("async_reset");
        chk("req037_count0", 32'(count), 32'd0);
        chk("req037_ovf0", 32'(overflow), 32'd0);
        #2;
        reset = 1'b1;
        rd_en = 1'b1;
        step("post_reset_rd");
        chk("req037_rd_valid0", 32'(rd_valid), 32'd0);
        repeat (5) step("held_after_reset");
        chk("req029_no_wr", 32'(count), 32'd0);
        RX_STATUS = 1'b0;
        step("status_low");
        RX_DATA   = 8'h3C;
        RX_STATUS = 1'b1;
        step("wr_on_empty_rd");
        chk("req021_write_only", 32'(count), 32'd1);
        RX_STATUS = 1'b0;
        step("drain");
        rd_en = 1'b0;
        step("drain_done");

        // Write/read pairs across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            pulse(8'($urandom_range(0, 255)), "pair_wr");
            rd_en = 1'b1;
            step("pair_rd");
            rd_en = 1'b0;
        end

        // Random traffic: first biased to fill, then biased to drain.
        for (int i = 0; i < 600; i++) begin
            RX_DATA   = 8'($urandom_range(0, 255));
            RX_STATUS = 1'($urandom_range(0, 1));
            rd_en     = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
